servo_pwm_multi: RTL and testbench
==================================

# servo_pwm_multi

Multi-channel servo PWM generator with parametrised frame period, per-channel runtime-programmable pulse widths, and glitch-free updates at frame boundaries. It replaces the fixed two-position servo driver. A host-side register interface (valid/ready) writes target pulse widths. All channels share one frame counter in the clk_30MHz domain and drive the servo pins directly.

## Interface
- NUM_CH, 4: number of servo channels (1..16)
- CNT_W, 20: frame counter and pulse-width width; must hold PERIOD_CLK-1
- PERIOD_CLK, 600000: frame length in clocks (20 ms at 30 MHz)
- PULSE_MIN, 30000: minimum legal pulse width (1 ms, 0 deg)
- PULSE_MAX, 60000: maximum legal pulse width (2 ms, 180 deg); PULSE_MIN <= PULSE_MAX < PERIOD_CLK
- STEP, 300: maximum per-frame change of active width when slew limiting is compiled in
- clk_30MHz  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_ch  in  max(1,$clog2(NUM_CH))  target channel
- wr_pulse  in  CNT_W  requested pulse width in clocks
- servo_pwm  out  NUM_CH  PWM outputs, bit i = channel i
- frame_start  out  1  one-cycle strobe marking the first output cycle of each frame
- busy  out  1  high while any channel's active width differs from its target

## Operation
- Frame counter cnt runs 0..PERIOD_CLK-1, then wraps to 0. The cycle where cnt == PERIOD_CLK-1 is the commit cycle.
- Each channel holds a target register and an active register. Writes update target only. Active is updated only in the commit cycle and takes effect from the next frame.
- Write clamping: wr_pulse < PULSE_MIN stores PULSE_MIN. wr_pulse > PULSE_MAX stores PULSE_MAX.
- wr_ch >= NUM_CH: the handshake completes and the write is dropped.
- wr_ready = 0 in the commit cycle and 1 otherwise. A write is therefore never coincident with a commit.
- Repeated writes to one channel within a frame: the last accepted write wins.
- Output: servo_pwm[i] is a registered version of (cnt < active[i]).
- frame_start is a registered version of (cnt == 0).
- busy is a registered OR over channels of (active[i] != target[i]).
- Reset values:
  - cnt = 0
  - target[i] = active[i] = PULSE_MIN
  - servo_pwm = 0, frame_start = 0, busy = 0
  - wr_ready = 1 from the first cycle after reset deasserts
- Reset mid-frame aborts the frame. Any pulse in progress ends at the next clock edge.

## Timing
- Output latency is 1 cycle from the cnt value to servo_pwm/frame_start.
- First cycle after reset release: cnt = 0. On the following edge, servo_pwm = all 1s (PULSE_MIN > 0) and frame_start = 1.
- Each pulse is high for exactly active[i] cycles per frame. The frame is exactly PERIOD_CLK cycles edge to edge.
- Write-to-output latency: a write accepted in frame N changes the pulse in frame N+1. Exception: if slew limiting is enabled, full convergence may take longer.
- busy updates 1 cycle after a target or active change.

## Configuration
- SERVO_PWM_SLEW_EN defined: at each commit, active[i] moves toward target[i] by min(STEP, |target[i]-active[i]|). The arithmetic uses CNT_W+1 bits and cannot overshoot, so active settles exactly on target.
- SERVO_PWM_SLEW_EN undefined: at each commit, active[i] = target[i]. STEP is ignored, and busy is high only between an accepted write and the next commit.

## Test plan
Bench parameters: NUM_CH=2, CNT_W=8, PERIOD_CLK=100, PULSE_MIN=10, PULSE_MAX=20, STEP=3.
- Reset release with no writes:
  - both channels high exactly 10 cycles every 100 cycles
  - frame_start strobes every 100 cycles, aligned with the rising edges
  - busy = 0
- Write ch1 = 15 at cnt = 40:
  - current frame unchanged
  - ch1 high 15 cycles from the next frame on (slew off)
  - with slew on, the widths are 13, 15
  - ch0 stays at 10
- Write ch0 = 5, then ch0 = 250:
  - the stored targets are 10 and 20
  - final width is 20
- Hold wr_valid across a wrap: wr_ready = 0 only at cnt = 99, and the write is accepted at cnt = 0.
- Write wr_ch = 3:
  - handshake completes
  - no channel changes
  - busy stays 0
- Assert reset at cnt = 5 during a pulse:
  - servo_pwm = 0 on the next edge
  - after release, the frame restarts at cnt = 0 with widths of 10

Source files
------------

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: one shared frame counter, per-channel target/active widths committed at frame end.
// Define SERVO_PWM_SLEW_EN to limit each commit's change of active width to STEP clocks.
module servo_pwm_multi #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 20,
    parameter int PERIOD_CLK = 600000,
    parameter int PULSE_MIN  = 30000,
    parameter int PULSE_MAX  = 60000,
    parameter int STEP       = 300
) (
    input  logic                                     clk_30MHz,
    input  logic                                     reset,
    input  logic                                     wr_valid,
    output logic                                     wr_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
    input  logic [CNT_W-1:0]                         wr_pulse,
    output logic [NUM_CH-1:0]                        servo_pwm,
    output logic                                     frame_start,
    output logic                                     busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CLK - 1);
    localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(PULSE_MIN);
    localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(PULSE_MAX);

    function automatic logic [CNT_W-1:0] clamp_pulse(input logic [CNT_W-1:0] p);
        if (p < MIN_W)
            clamp_pulse = MIN_W;
        else if (p > MAX_W)
            clamp_pulse = MAX_W;
        else
            clamp_pulse = p;
    endfunction

    // One extra bit keeps the signed difference exact, so the step never overshoots the target.
    function automatic logic [CNT_W-1:0] slew_step(input logic [CNT_W-1:0] act,
                                                   input logic [CNT_W-1:0] tgt);
        logic signed [CNT_W:0] diff;
        logic signed [CNT_W:0] step_s;
        diff   = $signed({1'b0, tgt}) - $signed({1'b0, act});
        step_s = $signed((CNT_W + 1)'(STEP));
        if (diff > step_s)
            slew_step = act + CNT_W'(STEP);
        else if (diff < -step_s)
            slew_step = act - CNT_W'(STEP);
        else
            slew_step = tgt;
    endfunction

    logic [CNT_W-1:0]  cnt_p0;
    logic [CNT_W-1:0]  target [NUM_CH];
    logic [CNT_W-1:0]  active [NUM_CH];
    logic              commit;
    logic              wr_accept;
    logic              any_diff;
    logic [NUM_CH-1:0] pwm_p1;
    logic              frame_start_p1;
    logic              busy_p1;

    assign commit    = (cnt_p0 == LAST_CNT);
    assign wr_ready  = ~commit;
    assign wr_accept = wr_valid && wr_ready && (int'(wr_ch) < NUM_CH);

    // Stage p0: frame counter and width registers
    always_ff @(posedge clk_30MHz) begin
        if (reset || commit)
            cnt_p0 <= '0;
        else
            cnt_p0 <= cnt_p0 + 1'b1;
    end

    always_ff @(posedge clk_30MHz) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                target[i] <= MIN_W;
                active[i] <= MIN_W;
            end
        end else begin
            if (wr_accept)
                target[wr_ch] <= clamp_pulse(wr_pulse);
            if (commit) begin
                for (int i = 0; i < NUM_CH; i++) begin
`ifdef SERVO_PWM_SLEW_EN
                    active[i] <= slew_step(active[i], target[i]);
`else
                    active[i] <= target[i];
`endif
                end
            end
        end
    end

    always_comb begin
        any_diff = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (active[i] != target[i])
                any_diff = 1'b1;
    end

    // Stage p1: registered pin outputs
    always_ff @(posedge clk_30MHz) begin
        if (reset) begin
            pwm_p1         <= '0;
            frame_start_p1 <= 1'b0;
            busy_p1        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                pwm_p1[i] <= (cnt_p0 < active[i]);
            frame_start_p1 <= (cnt_p0 == '0);
            busy_p1        <= any_diff;
        end
    end

    assign servo_pwm   = pwm_p1;
    assign frame_start = frame_start_p1;
    assign busy        = busy_p1;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: per-channel pulse-width scoreboard, per-cycle busy/wr_ready model,
// table-driven writes, plus wrap, out-of-range channel and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_servo_pwm_multi;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int PERIOD = 100;
    localparam int PMIN   = 10;
    localparam int PMAX   = 20;
    localparam int STEP   = 3;

    logic              clk_30MHz = 1'b0;
    logic              reset     = 1'b1;
    logic              wr_valid  = 1'b0;
    logic              wr_ready;
    logic [0:0]        wr_ch     = '0;
    logic [CNT_W-1:0]  wr_pulse  = '0;
    logic [NUM_CH-1:0] servo_pwm;
    logic              frame_start;
    logic              busy;

    // Three-channel instance so that an out-of-range channel number is representable
    logic              wr_valid_x = 1'b0;
    logic              wr_ready_x;
    logic [1:0]        wr_ch_x    = '0;
    logic [2:0]        servo_pwm_x;
    logic              frame_start_x;
    logic              busy_x;

    servo_pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD_CLK(PERIOD),
                      .PULSE_MIN(PMIN), .PULSE_MAX(PMAX), .STEP(STEP)) u_dut (
        .clk_30MHz(clk_30MHz), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_ch(wr_ch), .wr_pulse(wr_pulse), .servo_pwm(servo_pwm),
        .frame_start(frame_start), .busy(busy));

    servo_pwm_multi #(.NUM_CH(3), .CNT_W(CNT_W), .PERIOD_CLK(PERIOD),
                      .PULSE_MIN(PMIN), .PULSE_MAX(PMAX), .STEP(STEP)) u_dut_x (
        .clk_30MHz(clk_30MHz), .reset(reset), .wr_valid(wr_valid_x), .wr_ready(wr_ready_x),
        .wr_ch(wr_ch_x), .wr_pulse(wr_pulse), .servo_pwm(servo_pwm_x),
        .frame_start(frame_start_x), .busy(busy_x));

    always #5 clk_30MHz = ~clk_30MHz;

    typedef struct {
        int ch;
        int pulse;
        int exp_t;
    } wr_vec_t;

    int errors = 0;
    int checks = 0;
    int mcnt;
    int tgt [NUM_CH];
    int act [NUM_CH];
    bit busy_m;
    int wr_exp;
    int q0 [$];
    int q1 [$];

    task automatic check(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cnt=%0d)", name, got, exp_v, mcnt);
        end
    endtask

    function automatic int model_commit(input int a, input int t);
`ifdef SERVO_PWM_SLEW_EN
        if (t - a > STEP) return a + STEP;
        if (a - t > STEP) return a - STEP;
`endif
        return t;
    endfunction

    // One clock: advance the reference model, queue the next frame's widths, check busy/wr_ready.
    task automatic tick();
        bit acc;
        bit com;
        bit bnext;
        acc   = wr_valid && (mcnt != PERIOD - 1);
        com   = (mcnt == PERIOD - 1);
        bnext = (act[0] != tgt[0]) || (act[1] != tgt[1]);
        @(posedge clk_30MHz);
        #1;
        if (acc) tgt[wr_ch] = wr_exp;
        if (com) for (int i = 0; i < NUM_CH; i++) act[i] = model_commit(act[i], tgt[i]);
        mcnt   = (mcnt + 1) % PERIOD;
        busy_m = bnext;
        if (mcnt == 0) begin
            q0.push_back(act[0]);
            q1.push_back(act[1]);
        end
        check("busy", int'(busy), int'(busy_m));
        check("wr_ready", int'(wr_ready), int'(mcnt != PERIOD - 1));
    endtask

    task automatic run_to(input int c);
        do tick(); while (mcnt != c);
    endtask

    task automatic write(input int ch, input int pulse, input int exp_t);
        wr_valid = 1'b1;
        wr_ch    = 1'(ch);
        wr_pulse = CNT_W'(pulse);
        wr_exp   = exp_t;
        tick();
        wr_valid = 1'b0;
    endtask

    // Pulse-width monitor: pops the expected width of each channel at every falling edge.
    int         run0 = 0;
    int         run1 = 0;
    int         ncyc = 0;
    int         last_fs = -1;
    logic [1:0] prev_pwm = '0;

    always @(negedge clk_30MHz) begin
        ncyc++;
        if (reset) begin
            run0 = 0;
            run1 = 0;
            last_fs = -1;
            prev_pwm = '0;
        end else begin
            if (servo_pwm[0]) run0++;
            else if (run0 > 0) begin
                if (q0.size() == 0) check("ch0_unexpected_pulse", run0, 0);
                else check("ch0_width", run0, q0.pop_front());
                run0 = 0;
            end
            if (servo_pwm[1]) run1++;
            else if (run1 > 0) begin
                if (q1.size() == 0) check("ch1_unexpected_pulse", run1, 0);
                else check("ch1_width", run1, q1.pop_front());
                run1 = 0;
            end
            if (frame_start) begin
                check("fs_aligned_pwm", int'(servo_pwm), 3);
                check("fs_prev_pwm", int'(prev_pwm), 0);
                if (last_fs >= 0) check("frame_period", ncyc - last_fs, PERIOD);
                last_fs = ncyc;
            end else if ((servo_pwm & ~prev_pwm) != 2'b00) begin
                check("pwm_rise_without_fs", int'(servo_pwm), int'(prev_pwm));
            end
            prev_pwm = servo_pwm;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wr_vec_t vecs [8];
        int acc_at;
        vecs[0] = '{1, 15, 15};
        vecs[1] = '{0, 12, 12};
        vecs[2] = '{1, 0, 10};
        vecs[3] = '{0, 21, 20};
        vecs[4] = '{1, 20, 20};
        vecs[5] = '{0, 10, 10};
        vecs[6] = '{1, 19, 19};
        vecs[7] = '{0, 255, 20};

        mcnt = 0;
        busy_m = 1'b0;
        wr_exp = PMIN;
        for (int i = 0; i < NUM_CH; i++) begin
            tgt[i] = PMIN;
            act[i] = PMIN;
        end

        repeat (3) @(posedge clk_30MHz);
        #1;
        check("rst_pwm", int'(servo_pwm), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_ready", int'(wr_ready), 1);

        reset = 1'b0;
        q0.push_back(PMIN);
        q1.push_back(PMIN);
        tick();
        check("first_pwm", int'(servo_pwm), 3);
        check("first_frame_start", int'(frame_start), 1);
        run_to(0);
        run_to(0);

        // ch1 = 15 mid-frame: this frame unchanged, new width from the next one
        run_to(40);
        write(1, 15, 15);
        run_to(0);
        run_to(0);
        run_to(0);

        // Two writes to ch0 in one frame: 5 clamps to 10, 250 clamps to 20, last wins
        run_to(30);
        write(0, 5, 10);
        write(0, 250, 20);
        repeat (5) run_to(0);

        for (int v = 0; v < 8; v++) begin
            run_to(40);
            write(vecs[v].ch, vecs[v].pulse, vecs[v].exp_t);
        end
        run_to(0);
        run_to(0);

        // wr_valid held across the wrap: refused at cnt 99, accepted at cnt 0
        run_to(99);
        check("wrap_ready_at_99", int'(wr_ready), 0);
        wr_valid = 1'b1;
        wr_ch    = 1'b0;
        wr_pulse = CNT_W'(14);
        wr_exp   = 14;
        acc_at   = -1;
        for (int k = 0; k < 10 && acc_at < 0; k++) begin
            if (wr_ready) acc_at = mcnt;
            tick();
        end
        wr_valid = 1'b0;
        check("wrap_accept_cnt", acc_at, 0);
        run_to(0);
        run_to(0);

        // Out-of-range channel on the three-channel instance
        run_to(20);
        wr_valid_x = 1'b1;
        wr_ch_x    = 2'd3;
        wr_pulse   = CNT_W'(15);
        check("x_ready_handshake", int'(wr_ready_x), 1);
        tick();
        wr_valid_x = 1'b0;
        for (int k = 0; k < 110; k++) begin
            tick();
            check("x_busy", int'(busy_x), 0);
            check("x_frame_start", int'(frame_start_x), int'(mcnt == 1));
            if (mcnt == 10) check("x_pwm_last_high", int'(servo_pwm_x), 7);
            if (mcnt == 11) check("x_pwm_after_width", int'(servo_pwm_x), 0);
        end

        // Reset at cnt 5 while pulses are high
        run_to(5);
        check("pre_reset_pwm", int'(servo_pwm), 3);
        reset = 1'b1;
        @(posedge clk_30MHz);
        #1;
        check("reset_pwm_cut", int'(servo_pwm), 0);
        check("reset_frame_start", int'(frame_start), 0);
        check("reset_busy", int'(busy), 0);
        mcnt = 0;
        busy_m = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            tgt[i] = PMIN;
            act[i] = PMIN;
        end
        q0.delete();
        q1.delete();
        reset = 1'b0;
        q0.push_back(PMIN);
        q1.push_back(PMIN);
        tick();
        check("restart_pwm", int'(servo_pwm), 3);
        check("restart_frame_start", int'(frame_start), 1);
        run_to(0);
        run_to(50);

        check("ch0_pending_widths", q0.size(), 0);
        check("ch1_pending_widths", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
